// File: rtl/conv_seq_controller.sv
// Multi-channel convolution sequencer: coefficient load, window fill, tap-by-tap MAC,
// result hand-off with back-pressure and one-sample window shift, for NUM_CH channels.
module conv_seq_controller #(
  parameter int NUM_TAPS = 8,
  parameter int NUM_OUT  = 16,
  parameter int NUM_CH   = 4,
  localparam int TW = ($clog2(NUM_TAPS) < 1) ? 1 : $clog2(NUM_TAPS),
  localparam int OW = ($clog2(NUM_OUT)  < 1) ? 1 : $clog2(NUM_OUT),
  localparam int CW = ($clog2(NUM_CH)   < 1) ? 1 : $clog2(NUM_CH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          conv_en,
  input  logic          reload_coeff,
  input  logic          abort,
  input  logic          in_valid,
  input  logic          result_ready,
  output logic          coeff_req,
  output logic          sample_req,
  output logic          coeff_wr_en,
  output logic          sample_wr_en,
  output logic [TW-1:0] tap_idx,
  output logic          mac_en,
  output logic          mac_clear,
  output logic          shift,
  output logic          result_valid,
  output logic [OW-1:0] out_idx,
  output logic [CW-1:0] ch_sel,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_COEFF, S_FILL, S_MAC, S_RESULT, S_SHIFT, S_NEXT_CH, S_DONE
  } state_t;

  localparam logic [TW-1:0] TAP_LAST = TW'(NUM_TAPS - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NUM_OUT - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

  state_t        state, state_nx;
  logic [TW-1:0] tap_cnt, tap_nx;
  logic [OW-1:0] out_cnt, out_nx;
  logic [CW-1:0] ch_cnt, ch_nx;
  logic          coeff_loaded, loaded_nx;

  // n_rst is active-high and synchronous
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state        <= S_IDLE;
      tap_cnt      <= '0;
      out_cnt      <= '0;
      ch_cnt       <= '0;
      coeff_loaded <= 1'b0;
    end else begin
      state        <= state_nx;
      tap_cnt      <= tap_nx;
      out_cnt      <= out_nx;
      ch_cnt       <= ch_nx;
      coeff_loaded <= loaded_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    tap_nx       = tap_cnt;
    out_nx       = out_cnt;
    ch_nx        = ch_cnt;
    loaded_nx    = coeff_loaded;
    coeff_req    = 1'b0;
    sample_req   = 1'b0;
    coeff_wr_en  = 1'b0;
    sample_wr_en = 1'b0;
    tap_idx      = '0;
    mac_en       = 1'b0;
    mac_clear    = 1'b0;
    shift        = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;

    case (state)
      S_IDLE: begin
        if (conv_en) begin
          tap_nx   = '0;
          out_nx   = '0;
          ch_nx    = '0;
          state_nx = (reload_coeff || !coeff_loaded) ? S_LOAD_COEFF : S_FILL;
        end
      end
      S_LOAD_COEFF: begin
        coeff_req   = 1'b1;
        coeff_wr_en = in_valid;
        tap_idx     = tap_cnt;
        if (in_valid) begin
          if (tap_cnt == TAP_LAST) begin
            tap_nx    = '0;
            loaded_nx = 1'b1;
            state_nx  = S_FILL;
          end else begin
            tap_nx = tap_cnt + TW'(1);
          end
        end
      end
      S_FILL: begin
        sample_req   = 1'b1;
        sample_wr_en = in_valid;
        tap_idx      = tap_cnt;
        if (in_valid) begin
          if (tap_cnt == TAP_LAST) begin
            tap_nx   = '0;
            state_nx = S_MAC;
          end else begin
            tap_nx = tap_cnt + TW'(1);
          end
        end
      end
      S_MAC: begin
        mac_en    = 1'b1;
        mac_clear = (tap_cnt == '0);
        tap_idx   = tap_cnt;
        if (tap_cnt == TAP_LAST) begin
          tap_nx   = '0;
          state_nx = S_RESULT;
        end else begin
          tap_nx = tap_cnt + TW'(1);
        end
      end
      S_RESULT: begin
        result_valid = 1'b1;
        if (result_ready) begin
          if (out_cnt == OUT_LAST) begin
            state_nx = S_NEXT_CH;
          end else begin
            out_nx   = out_cnt + OW'(1);
            state_nx = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        // the shifted-in sample always lands in the newest window slot
        sample_req   = 1'b1;
        sample_wr_en = in_valid;
        shift        = in_valid;
        tap_idx      = TAP_LAST;
        if (in_valid) state_nx = S_MAC;
      end
      S_NEXT_CH: begin
        out_nx = '0;
        if (ch_cnt == CH_LAST) begin
          state_nx = S_DONE;
        end else begin
          ch_nx    = ch_cnt + CW'(1);
          state_nx = S_FILL;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // abort overrides every transition; a half-written coefficient set is invalid
    if (abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      tap_nx   = '0;
      out_nx   = '0;
      ch_nx    = '0;
      if (state == S_LOAD_COEFF) loaded_nx = 1'b0;
    end
  end

  assign busy    = (state != S_IDLE);
  assign out_idx = out_cnt;
  assign ch_sel  = ch_cnt;

endmodule

// File: tb/tb_conv_seq_controller.sv
// Bench for conv_seq_controller: directed timing scenarios plus randomized handshakes,
// checked against an ordered event list derived from the run structure.
module tb_conv_seq_controller;
  localparam int T = 4, O = 3, C = 2;

  logic clk = 1'b0, n_rst = 1'b1;
  logic conv_en = 1'b0, reload_coeff = 1'b0, abort = 1'b0, in_valid = 1'b0, result_ready = 1'b0;
  logic coeff_req, sample_req, coeff_wr_en, sample_wr_en, mac_en, mac_clear, shift;
  logic result_valid, busy, done;
  logic [1:0] tap_idx;
  logic [1:0] out_idx;
  logic [0:0] ch_sel;

  conv_seq_controller #(.NUM_TAPS(T), .NUM_OUT(O), .NUM_CH(C)) dut (
    .clk(clk), .n_rst(n_rst), .conv_en(conv_en), .reload_coeff(reload_coeff), .abort(abort),
    .in_valid(in_valid), .result_ready(result_ready), .coeff_req(coeff_req),
    .sample_req(sample_req), .coeff_wr_en(coeff_wr_en), .sample_wr_en(sample_wr_en),
    .tap_idx(tap_idx), .mac_en(mac_en), .mac_clear(mac_clear), .shift(shift),
    .result_valid(result_valid), .out_idx(out_idx), .ch_sel(ch_sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int obs[$], exp_q[$];
  int n_coeff_req, n_coeff_wr, n_mac, n_clear, n_rv, n_shift, n_done;
  bit model_loaded = 1'b0;

  // event code: kind*1000 + tap*100 + out*10 + ch
  // kinds: 1 coeff write, 2 fill write, 3 shift write, 4 mac, 5 mac+clear, 6 result xfer, 7 done
  function automatic int ev(int k, int t, int o, int c);
    return k * 1000 + t * 100 + o * 10 + c;
  endfunction

  always @(negedge clk) begin
    if (coeff_wr_en) obs.push_back(ev(1, tap_idx, out_idx, ch_sel));
    if (sample_wr_en) obs.push_back(ev(shift ? 3 : 2, tap_idx, out_idx, ch_sel));
    if (mac_en) obs.push_back(ev(mac_clear ? 5 : 4, tap_idx, out_idx, ch_sel));
    if (result_valid && result_ready) obs.push_back(ev(6, tap_idx, out_idx, ch_sel));
    if (done) obs.push_back(ev(7, tap_idx, out_idx, ch_sel));
    n_coeff_req += int'(coeff_req);
    n_coeff_wr  += int'(coeff_wr_en);
    n_mac       += int'(mac_en);
    n_clear     += int'(mac_clear);
    n_rv        += int'(result_valid);
    n_shift     += int'(shift);
    n_done      += int'(done);
  end

  // Expected event order of one complete run
  task automatic build_exp(input bit load);
    exp_q.delete();
    if (load) for (int t = 0; t < T; t++) exp_q.push_back(ev(1, t, 0, 0));
    for (int c = 0; c < C; c++) begin
      for (int t = 0; t < T; t++) exp_q.push_back(ev(2, t, 0, c));
      for (int o = 0; o < O; o++) begin
        for (int t = 0; t < T; t++) exp_q.push_back(ev(t == 0 ? 5 : 4, t, o, c));
        exp_q.push_back(ev(6, 0, o, c));
        if (o < O - 1) exp_q.push_back(ev(3, T - 1, o + 1, c));
      end
    end
    exp_q.push_back(ev(7, 0, 0, C - 1));
  endtask

  task automatic clear_mon();
    obs.delete();
    n_coeff_req = 0; n_coeff_wr = 0; n_mac = 0; n_clear = 0;
    n_rv = 0; n_shift = 0; n_done = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input bit reload);
    conv_en = 1'b1; reload_coeff = reload;
    step();
    conv_en = 1'b0; reload_coeff = 1'b0;
  endtask

  task automatic run_to_done(input bit rnd, output int n);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      if (rnd) begin
        in_valid = 1'($urandom_range(0, 1));
        result_ready = 1'($urandom_range(0, 1));
      end
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL run_timeout: done=%b after %0d edges, required 1", done, n);
    end
    step();
  endtask

  task automatic check_events(input string name);
    int n;
    checks++;
    if (obs.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: events=%0d required=%0d", name, obs.size(), exp_q.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_event[%0d]: got %0d required %0d", name, i, obs[i], exp_q[i]);
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b1; conv_en = 1'b1; abort = 1'b1; in_valid = 1'b1; result_ready = 1'b1;
    step(); step();
    checks++;
    if ({coeff_req, sample_req, coeff_wr_en, sample_wr_en, tap_idx, mac_en, mac_clear, shift,
         result_valid, out_idx, ch_sel, busy, done} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b coeff_req=%b sample_req=%b tap=%0d required all 0",
               busy, coeff_req, sample_req, tap_idx);
    end
    n_rst = 1'b0; conv_en = 1'b0; abort = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
    step();
  endtask

  task automatic test_full_run();
    int n;
    in_valid = 1'b1; result_ready = 1'b1;
    clear_mon();
    build_exp(1'b1);
    start_run(1'b1);
    run_to_done(1'b0, n);
    model_loaded = 1'b1;
    checks++; if (n !== 48) begin failures++; $display("FAIL full_done_edge: got %0d required 48", n); end
    checks++; if (n_coeff_wr !== 4) begin failures++; $display("FAIL full_coeff_wr: got %0d required 4", n_coeff_wr); end
    checks++; if (n_mac !== 24) begin failures++; $display("FAIL full_mac_en: got %0d required 24", n_mac); end
    checks++; if (n_clear !== 6) begin failures++; $display("FAIL full_mac_clear: got %0d required 6", n_clear); end
    checks++; if (n_rv !== 6) begin failures++; $display("FAIL full_result_valid: got %0d required 6", n_rv); end
    checks++; if (n_shift !== 4) begin failures++; $display("FAIL full_shift: got %0d required 4", n_shift); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_idle_after: busy=%b required 0", busy); end
    check_events("full");
  endtask

  task automatic test_reuse();
    int n;
    in_valid = 1'b1; result_ready = 1'b1;
    clear_mon();
    build_exp(1'b0);
    start_run(1'b0);
    run_to_done(1'b0, n);
    checks++; if (n !== 44) begin failures++; $display("FAIL reuse_done_edge: got %0d required 44", n); end
    checks++; if (n_coeff_req !== 0) begin failures++; $display("FAIL reuse_coeff_req: got %0d required 0", n_coeff_req); end
    checks++; if (n_coeff_wr !== 0) begin failures++; $display("FAIL reuse_coeff_wr: got %0d required 0", n_coeff_wr); end
    check_events("reuse");
  endtask

  task automatic test_stall();
    int n = 0;
    in_valid = 1'b1; result_ready = 1'b0;
    clear_mon();
    build_exp(1'b0);
    start_run(1'b0);
    while (result_valid !== 1'b1 && n < 100) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (result_valid !== 1'b1 || out_idx !== 2'd0 || mac_en !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: rv=%b out_idx=%0d mac_en=%b required 1,0,0",
                 i, result_valid, out_idx, mac_en);
      end
      step();
    end
    result_ready = 1'b1;
    checks++;
    if (result_valid !== 1'b1 || out_idx !== 2'd0) begin
      failures++;
      $display("FAIL stall_sixth: rv=%b out_idx=%0d required 1,0", result_valid, out_idx);
    end
    step();
    checks++;
    if (result_valid !== 1'b0) begin
      failures++; $display("FAIL stall_release: rv=%b required 0", result_valid);
    end
    run_to_done(1'b0, n);
    check_events("stall");
  endtask

  task automatic test_fill_toggle();
    int n;
    in_valid = 1'b0; result_ready = 1'b1;
    clear_mon();
    build_exp(1'b0);
    start_run(1'b0);
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      #1;
      checks++;
      if (sample_wr_en !== in_valid || (in_valid && tap_idx !== 2'(i / 2))) begin
        failures++;
        $display("FAIL fill_beat[%0d]: wr=%b tap=%0d required wr=%b tap=%0d",
                 i, sample_wr_en, tap_idx, in_valid, i / 2);
      end
      step();
    end
    checks++;
    if (mac_en !== 1'b1 || mac_clear !== 1'b1 || tap_idx !== 2'd0) begin
      failures++;
      $display("FAIL fill_mac_start: mac_en=%b clear=%b tap=%0d required 1,1,0",
               mac_en, mac_clear, tap_idx);
    end
    in_valid = 1'b1;
    run_to_done(1'b0, n);
    check_events("fill");
  endtask

  task automatic test_abort();
    int n = 0;
    in_valid = 1'b1; result_ready = 1'b1;
    clear_mon();
    start_run(1'b0);
    while (!(ch_sel === 1'b1 && mac_en === 1'b1 && tap_idx === 2'd1) && n < 200) begin
      step(); n++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ch_sel !== 1'b0 || out_idx !== 2'd0) begin
      failures++;
      $display("FAIL abort_idle: busy=%b ch=%0d out=%0d required 0,0,0", busy, ch_sel, out_idx);
    end
    step(); step();
    checks++;
    if (n_done !== 0) begin failures++; $display("FAIL abort_no_done: done pulses=%0d required 0", n_done); end
    clear_mon();
    build_exp(1'b0);
    start_run(1'b0);
    checks++;
    if (sample_req !== 1'b1 || coeff_req !== 1'b0) begin
      failures++;
      $display("FAIL abort_restart: sample_req=%b coeff_req=%b required 1,0", sample_req, coeff_req);
    end
    run_to_done(1'b0, n);
    check_events("abort");
  endtask

  task automatic test_reset_mid_load();
    int n;
    in_valid = 1'b1; result_ready = 1'b1;
    start_run(1'b1);
    step(); step();
    n_rst = 1'b1; abort = 1'b1; conv_en = 1'b1; reload_coeff = 1'b0;
    step();
    checks++;
    if ({coeff_req, sample_req, coeff_wr_en, sample_wr_en, tap_idx, mac_en, mac_clear, shift,
         result_valid, out_idx, ch_sel, busy, done} !== 16'h0) begin
      failures++;
      $display("FAIL rstload_outputs: busy=%b coeff_req=%b coeff_wr=%b tap=%0d required all 0",
               busy, coeff_req, coeff_wr_en, tap_idx);
    end
    n_rst = 1'b0; abort = 1'b0;
    clear_mon();
    build_exp(1'b1);
    step();
    conv_en = 1'b0;
    checks++;
    if (coeff_req !== 1'b1 || tap_idx !== 2'd0) begin
      failures++;
      $display("FAIL rstload_reload: coeff_req=%b tap=%0d required 1,0", coeff_req, tap_idx);
    end
    run_to_done(1'b0, n);
    model_loaded = 1'b1;
    check_events("rstload");
  endtask

  task automatic test_random();
    int n;
    bit rl;
    for (int r = 0; r < 6; r++) begin
      rl = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      result_ready = 1'($urandom_range(0, 1));
      clear_mon();
      build_exp(rl || !model_loaded);
      model_loaded = 1'b1;
      start_run(rl);
      run_to_done(1'b1, n);
      check_events($sformatf("rand%0d", r));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_run();
    test_reuse();
    test_stall();
    test_fill_toggle();
    test_abort();
    test_reset_mid_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_seq_controller.md
Name: conv_seq_controller

Overview:
- Parametrised, multi-channel successor to the single-channel convolution sequencer.
- Sequences coefficient load, window fill, tap-by-tap MAC, result hand-off and sample shift for NUM_CH channels and NUM_OUT outputs per channel.
- Adds a tap index, coefficient reuse across runs, abort, and result back-pressure.
- Sits between the sample/coefficient input stream and the MAC datapath.

Parameters:
- NUM_TAPS, 8: coefficients per filter and samples per window (≥2).
- NUM_OUT, 16: outputs produced per channel (≥1).
- NUM_CH, 4: channels processed sequentially (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge
- n_rst  in  1  reset, synchronous and active-high
- conv_en  in  1  start request, sampled only in IDLE
- reload_coeff  in  1  sampled with conv_en; 1 forces a coefficient load
- abort  in  1  cancel run
- in_valid  in  1  input stream beat available
- result_ready  in  1  downstream accepts result
- coeff_req  out  1  block wants coefficient beats
- sample_req  out  1  block wants sample beats
- coeff_wr_en  out  1  coefficient beat accepted this cycle
- sample_wr_en  out  1  sample beat accepted this cycle
- tap_idx  out  max(1,$clog2(NUM_TAPS))  write address or current tap
- mac_en  out  1  MAC step this cycle
- mac_clear  out  1  clear accumulator, tap 0 only
- shift  out  1  shift window by one sample
- result_valid  out  1  accumulator result valid
- out_idx  out  max(1,$clog2(NUM_OUT))  output index in channel
- ch_sel  out  max(1,$clog2(NUM_CH))  active channel
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle run-complete pulse

Behaviour:
- Moore outputs decoded from registered state and counters. Exceptions: coeff_wr_en, sample_wr_en and shift equal their state condition AND in_valid.
- Reset (n_rst=1 at edge):
  - state=IDLE; all counters and the coeff_loaded flag cleared.
  - All outputs 0.
- IDLE:
  - On conv_en, next state is LOAD_COEFF if reload_coeff=1 or coeff_loaded=0; otherwise FILL.
  - ch_sel=0 and out_idx=0 on entry to the run.
- LOAD_COEFF:
  - coeff_req=1.
  - Each in_valid cycle: coeff_wr_en=1 with tap_idx=k, then k increments.
  - After beat NUM_TAPS-1: set coeff_loaded, go to FILL.
- FILL:
  - sample_req=1.
  - Each in_valid cycle: sample_wr_en=1 with tap_idx=k.
  - After NUM_TAPS beats: go to MAC.
- MAC:
  - Exactly NUM_TAPS cycles, with mac_en=1 and tap_idx=0..NUM_TAPS-1.
  - mac_clear=1 only in the tap 0 cycle.
  - Then go to RESULT.
- RESULT:
  - result_valid=1 and held until result_ready; transfer occurs when both are 1.
  - On transfer: if out_idx=NUM_OUT-1, go to NEXT_CH; else out_idx+1 and go to SHIFT.
- SHIFT:
  - sample_req=1.
  - On in_valid: shift=1, sample_wr_en=1, tap_idx=NUM_TAPS-1, go to MAC.
- NEXT_CH:
  - One cycle; out_idx←0.
  - If ch_sel=NUM_CH-1: go to DONE with ch_sel held. Else ch_sel+1 and go to FILL.
- DONE: done=1 for one cycle, then IDLE.
- tap_idx is 0 in IDLE, RESULT, NEXT_CH and DONE.
- abort:
  - In any non-IDLE state, next state is IDLE and all counters clear.
  - If aborted in LOAD_COEFF, coeff_loaded clears; otherwise it is retained.
  - done is not pulsed.
  - abort has priority over every other transition; n_rst has priority over abort.
- conv_en is ignored while busy.
- Counters wrap only via explicit clear; they never free-run.
- in_valid outside LOAD_COEFF, FILL and SHIFT is ignored, and no wr_en is asserted.

Test Plan:
- NUM_TAPS=4, NUM_OUT=3, NUM_CH=2; in_valid=1, result_ready=1; conv_en+reload_coeff pulse.
  - Expect: 4 coeff_wr_en (tap_idx 0..3), 24 mac_en, 6 mac_clear, 6 result_valid, 4 shift.
  - done high in the state entered 48 edges after the conv_en edge.
- Repeat the run with reload_coeff=0 → no coeff_req or coeff_wr_en; done 44 edges after conv_en.
- Hold result_ready=0 for 5 cycles at the first RESULT → result_valid high for 6 cycles; out_idx stable at 0; no mac_en during the stall.
- Toggle in_valid (1,0,1,0…) during FILL → 4 sample_wr_en on the in_valid=1 cycles only, tap_idx 0..3; MAC starts the cycle after the 4th beat.
- abort in the 2nd MAC cycle of ch_sel=1 → IDLE next cycle, busy=0, no done. A following conv_en with reload_coeff=0 skips LOAD_COEFF.
- n_rst and abort asserted together mid-LOAD_COEFF; conv_en held high → all outputs 0 and coeff_loaded=0. A next conv_en with reload_coeff=0 still enters LOAD_COEFF.
